input_mode_sequencer: RTL
=========================

Name: input_mode_sequencer

Overview:
- Front-end controller between the board buttons/switches and the three VGA function engines.
- Synchronises and debounces East/West/North/South/change, and converts presses to single-cycle pulses.
- Runs the function-select state machine (FUNC1 -> FUNC2 -> FUNC3 -> FUNC1) with a guard interval on every switch.
- Drives registered, mutually exclusive instruction buses so exactly one engine sees commands at a time.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable synced samples required to accept a button level change; legal range 1..2^20.
- GUARD_CYCLES, 16, cycles spent in SWITCH with all instruction buses forced to zero after a mode change; legal range 1..255.
- INIT_FUNC, 0, function index entered on reset; legal values 0..2.

Ports:
- sysclk  in  1  system clock; all state on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- East  in  1  raw button.
- West  in  1  raw button.
- North  in  1  raw button.
- South  in  1  raw button.
- change  in  1  raw mode-cycle button.
- SW  in  4  raw slide switches; SW[0] is the soft reset, SW[3:1] are data.
- func_index  out  2  current function, 0..2; holds the target value during SWITCH.
- func1_instruction  out  4  {SW3, SW2, SW1, East_pulse}.
- func2_instruction  out  4  {East_pulse, West_pulse, North_pulse, South_pulse}.
- func3_instruction  out  5  {East_pulse, West_pulse, North_pulse, South_pulse, SW3}.
- soft_reset  out  1  synchronised SW[0].
- busy  out  1  high while in SWITCH.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All sync flops, debounce counters, stable levels and pulses go to 0.
  - State = FUNCn with n = INIT_FUNC; func_index = INIT_FUNC.
  - All instruction buses = 0; soft_reset = 0; busy = 0.
- Synchroniser: a 2-flop chain on all 5 buttons and 4 switches. Switches are used level-only after synchronisation; they are not debounced.
- Debounce, per button:
  - A counter increments while the synced value differs from the stable value, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES, stable takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Pulse: a one-cycle pulse on each stable 0->1 edge. Release (1->0) produces nothing. A held button produces exactly one pulse.
- Latency: a raw rising edge held steady produces the instruction-bus bit high exactly DEBOUNCE_CYCLES+3 cycles after the first sysclk edge that samples it, for one cycle.
- FSM states: FUNC1, FUNC2, FUNC3, SWITCH.
  - In FUNCn, a change pulse loads the target (FUNC1->FUNC2->FUNC3->FUNC1, wrapping from index 2 to 0), sets func_index to the target the same cycle, loads the guard counter with GUARD_CYCLES, and enters SWITCH.
  - In SWITCH, the guard counter decrements each cycle. At 0 the FSM enters the target state.
  - busy = 1 and all instruction buses = 0 throughout SWITCH.
  - change pulses during SWITCH are ignored (no queueing).
- Output registers:
  - The instruction buses are registered; only the bus matching the active FUNCn is non-zero and the other two are 0.
  - A button pulse coinciding with the change pulse is dropped; the FSM leaves FUNCn that cycle and outputs are zeroed from the next cycle.
  - Simultaneous East and West pulses both appear in the same cycle.
- soft_reset: the synced SW[0] passed through one more register. It does not reset this block.
- Reset mid-SWITCH: the FSM returns to INIT_FUNC immediately and the guard counter is discarded.

Decomposition:
- Shared package input_pkg:
  - State encoding constants: FUNC1=2'd0, FUNC2=2'd1, FUNC3=2'd2, and a 2-bit state plus a SWITCH flag (or a 3-bit enum).
  - Function-index width constant.
  - Instruction bus widths: 4, 4, 5.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports sysclk, reset_n, raw, pulse, level), instantiated 5 times.
- The FSM and output muxing stay in the top module.

Test Plan:
- Reset: hold reset_n=0 with every input toggling -> all outputs 0, func_index=INIT_FUNC; release -> state unchanged until a change press.
- Clean press (DEBOUNCE_CYCLES=4) of East in FUNC1 with SW=4'b1010 -> func1_instruction = 4'b1011 for exactly 1 cycle, 7 cycles after the raw edge; then 4'b1010.
- Glitch: North high for 3 cycles (DEBOUNCE_CYCLES=4) in FUNC2 -> no pulse. Hold for 20 cycles -> exactly one pulse, func2_instruction = 4'b0010.
- Mode cycling (GUARD_CYCLES=3): three change presses spaced 50 cycles apart -> func_index goes 0->1->2->0; busy high for 3 cycles after each press; all buses 0 while busy.
- Second change press landing during SWITCH -> ignored, func_index advances by only 1.
- Reset asserted mid-SWITCH with target 2 -> immediate func_index=INIT_FUNC, busy=0; FUNC3 with SW3=1 plus South press -> func3_instruction = 5'b00011.

Source files
------------

// File: rtl/input_pkg.sv
// ---------------------------------------------------------------------------
// input_pkg : shared encodings and bus widths for input_mode_sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package input_pkg;

  localparam int FUNC_IDX_W = 2;
  localparam int STATE_W    = 3;

  localparam logic [FUNC_IDX_W-1:0] FUNC1 = 2'd0;
  localparam logic [FUNC_IDX_W-1:0] FUNC2 = 2'd1;
  localparam logic [FUNC_IDX_W-1:0] FUNC3 = 2'd2;

  // Bit 2 is the SWITCH flag; the low bits of a FUNCn state are its index.
  localparam logic [STATE_W-1:0] ST_FUNC1  = 3'b000;
  localparam logic [STATE_W-1:0] ST_FUNC2  = 3'b001;
  localparam logic [STATE_W-1:0] ST_FUNC3  = 3'b010;
  localparam logic [STATE_W-1:0] ST_SWITCH = 3'b100;

  localparam int F1_W = 4;
  localparam int F2_W = 4;
  localparam int F3_W = 5;

  localparam int NUM_BTN    = 5;
  localparam int BTN_EAST   = 0;
  localparam int BTN_WEST   = 1;
  localparam int BTN_NORTH  = 2;
  localparam int BTN_SOUTH  = 3;
  localparam int BTN_CHANGE = 4;

  function automatic logic [FUNC_IDX_W-1:0] next_func(input logic [FUNC_IDX_W-1:0] idx);
    return (idx >= FUNC3) ? FUNC1 : idx + 2'd1;
  endfunction

  function automatic logic [STATE_W-1:0] func_state(input logic [FUNC_IDX_W-1:0] idx);
    return {1'b0, idx};
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce : 2-flop sync, counter debounce and rising-edge pulse. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             prev_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (w_cnt_inc == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
      pulse_q  <= stable_q & ~prev_q;
    end
  end

  assign pulse = pulse_q;
  assign level = stable_q;

endmodule

`default_nettype wire

// File: rtl/input_mode_sequencer.sv
// ---------------------------------------------------------------------------
// input_mode_sequencer : button front-end and function-select FSM. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module input_mode_sequencer
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GUARD_CYCLES    = 16,
  parameter int INIT_FUNC       = 0
) (
  input  logic            sysclk,
  input  logic            reset_n,
  input  logic            East,
  input  logic            West,
  input  logic            North,
  input  logic            South,
  input  logic            change,
  input  logic [3:0]      SW,
  output logic [1:0]      func_index,
  output logic [F1_W-1:0] func1_instruction,
  output logic [F2_W-1:0] func2_instruction,
  output logic [F3_W-1:0] func3_instruction,
  output logic            soft_reset,
  output logic            busy
);

  localparam logic [FUNC_IDX_W-1:0] INIT_IDX   = FUNC_IDX_W'(INIT_FUNC);
  localparam logic [STATE_W-1:0]    INIT_STATE = func_state(INIT_IDX);
  localparam logic [7:0]            GUARD_INIT = 8'(GUARD_CYCLES);

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_btn_pulse;
  logic [NUM_BTN-1:0] w_btn_level_unused;

  assign w_btn_raw = {change, South, North, West, East};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .sysclk  (sysclk),
      .reset_n (reset_n),
      .raw     (w_btn_raw[gi]),
      .pulse   (w_btn_pulse[gi]),
      .level   (w_btn_level_unused[gi])
    );
  end

  logic w_e, w_w, w_n, w_s, w_chg;
  assign w_e   = w_btn_pulse[BTN_EAST];
  assign w_w   = w_btn_pulse[BTN_WEST];
  assign w_n   = w_btn_pulse[BTN_NORTH];
  assign w_s   = w_btn_pulse[BTN_SOUTH];
  assign w_chg = w_btn_pulse[BTN_CHANGE];

  // Switches are level signals: synchronised only, never debounced.
  logic [3:0] sw_s1_q;
  logic [3:0] sw_s2_q;
  logic       soft_reset_q;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      sw_s1_q      <= SW;
      sw_s2_q      <= sw_s1_q;
      soft_reset_q <= sw_s2_q[0];
    end
  end

  logic [STATE_W-1:0]    state_q, state_d;
  logic [FUNC_IDX_W-1:0] func_index_q, func_index_d;
  logic [7:0]            guard_q, guard_d;
  logic [7:0]            w_guard_dec;
  logic [F1_W-1:0]       f1_q, f1_d;
  logic [F2_W-1:0]       f2_q, f2_d;
  logic [F3_W-1:0]       f3_q, f3_d;

  assign w_guard_dec = guard_q - 8'd1;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT_STATE;
      func_index_q <= INIT_IDX;
      guard_q      <= '0;
      f1_q         <= '0;
      f2_q         <= '0;
      f3_q         <= '0;
    end else begin
      state_q      <= state_d;
      func_index_q <= func_index_d;
      guard_q      <= guard_d;
      f1_q         <= f1_d;
      f2_q         <= f2_d;
      f3_q         <= f3_d;
    end
  end

  // func_index already holds the target while switching.
  always_comb begin
    state_d      = state_q;
    func_index_d = func_index_q;
    guard_d      = guard_q;
    case (state_q)
      ST_SWITCH: begin
        guard_d = w_guard_dec;
        if (w_guard_dec == 8'd0) begin
          state_d = func_state(func_index_q);
        end
      end
      default: begin
        if (w_chg) begin
          func_index_d = next_func(state_q[FUNC_IDX_W-1:0]);
          guard_d      = GUARD_INIT;
          state_d      = ST_SWITCH;
        end
      end
    endcase
  end

  // A command arriving with the change pulse is dropped.
  always_comb begin
    f1_d = '0;
    f2_d = '0;
    f3_d = '0;
    if (!w_chg) begin
      case (state_q)
        ST_FUNC1: f1_d = {sw_s2_q[3], sw_s2_q[2], sw_s2_q[1], w_e};
        ST_FUNC2: f2_d = {w_e, w_w, w_n, w_s};
        ST_FUNC3: f3_d = {w_e, w_w, w_n, w_s, sw_s2_q[3]};
        default: ;
      endcase
    end
  end

  assign func_index        = func_index_q;
  assign func1_instruction = f1_q;
  assign func2_instruction = f2_q;
  assign func3_instruction = f3_q;
  assign soft_reset        = soft_reset_q;
  assign busy              = (state_q == ST_SWITCH);

endmodule

`default_nettype wire
